ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-client arbiter and sequencer for the shared RAM's write/read port B (`addr_b`, `in_data`, `write_en`, `data_b`). It accepts single-word read or write requests from two masters, such as the core and a program loader. It grants them round-robin, drives port B for exactly one cycle per access, and returns an acknowledge with registered read data. Port A (instruction fetch) is untouched by this block.

## Interface
- `ADDR_WIDTH`, 6, RAM address width; must match the RAM instance.
- `DATA_WIDTH`, 16, RAM word width; must match the RAM instance.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c0_req`, `c1_req`  in  1 each  level request from client 0 / client 1.
- `c0_we`, `c1_we`  in  1 each  1 = write, 0 = read; sampled with `req` at grant.
- `c0_addr`, `c1_addr`  in  ADDR_WIDTH each  word address; sampled at grant.
- `c0_wdata`, `c1_wdata`  in  DATA_WIDTH each  write data; sampled at grant.
- `c0_gnt`, `c1_gnt`  out  1 each  one-cycle pulse: request accepted this cycle.
- `c0_ack`, `c1_ack`  out  1 each  one-cycle pulse: access completed.
- `c0_rdata`, `c1_rdata`  out  DATA_WIDTH each  read result; valid while `ack` is high; holds its value otherwise.
- `busy`  out  1  high while in ACCESS.
- `ram_addr_b`  out  ADDR_WIDTH  to RAM `addr_b`.
- `ram_in_data`  out  DATA_WIDTH  to RAM `in_data`.
- `ram_write_en`  out  1  to RAM `write_en`.
- `ram_data_b`  in  DATA_WIDTH  from RAM `data_b` (combinational read).

## Operation
- FSM has two states, IDLE and ACCESS. Registers: `state`, `ptr` (priority client), `owner`, `we_q`, `addr_q`, `wdata_q`, `c0_rdata`, `c1_rdata`, and the ack flops.
- **IDLE, no request:** stay in IDLE.
- **IDLE, any `req`:** choose the winner.
  - Only one client requesting: that client wins.
  - Both requesting: client `ptr` wins.
- **On a grant:**
  - `gnt[winner]` = 1, combinationally in the IDLE cycle.
  - Latch `owner`, `we_q`, `addr_q`, `wdata_q` from the winner.
  - `ptr` <= ~winner.
  - Next state is ACCESS.
- **ACCESS:**
  - Drive `ram_addr_b` = `addr_q`, `ram_in_data` = `wdata_q`, `ram_write_en` = `we_q`.
  - On the closing edge the RAM commits a write. For a read, the edge captures `ram_data_b` into `c<owner>_rdata`.
  - Set `c<owner>_ack` for the next cycle. Return to IDLE.
- **Outside ACCESS:** `ram_write_en` = 0. `ram_addr_b` and `ram_in_data` hold their last values, so no spurious writes occur.
- **Requests during ACCESS:** ignored (no grant). They are considered again in the next IDLE cycle.
- **Request lifetime:** `req` is level-sensitive. A client wanting a single access must drop `req` by the IDLE cycle in which its `ack` pulses. Otherwise it is re-arbitrated, and granted if it wins.
- **Write acks:** `ack` also pulses for writes; `rdata` is unchanged on a write ack.

## Timing
- Reset (async assert, sync deassert by the system):
  - `state` = IDLE, `ptr` = 0, `owner` = 0.
  - All `gnt`, `ack`, `busy`, `ram_write_en` = 0.
  - `ram_addr_b`, `ram_in_data`, `c0_rdata`, `c1_rdata` = 0.
- **Latency:** `req` seen in IDLE at cycle N produces `gnt` at N. ACCESS occupies N+1. `ack` and valid `rdata` appear at N+2.
- **Throughput:** one access per 2 cycles. Cycle N+2 is IDLE and may grant again, concurrently with the `ack`.
- **Fairness:** with both clients holding `req`, grants strictly alternate. Neither client waits more than one access.
- **Reset mid-ACCESS:** `ram_write_en` drops immediately and no write occurs. No `ack` is issued and the transaction is lost.
- **Address wrap:** none; addresses are used as-is. Full range 0 to 2^ADDR_WIDTH-1 is legal.

## Test plan
- After reset, client 0 writes 0x1234 to address 5, then reads address 5. Expect `c0_gnt` at N, `ram_write_en`=1 only at N+1, `c0_ack` at N+2. The read ack returns `c0_rdata`=0x1234.
- Both clients hold `req` continuously: c0 writes 0xAAAA to address 1, c1 writes 0x5555 to address 2. Expect grants in order c0, c1, c0, c1…, 2 cycles apart, and RAM addresses 1 and 2 holding their values.
- c1 alone requests a read of address 0 after reset. Expect c1 granted immediately even though `ptr`=0. Next, a simultaneous request from both is granted to c0.
- c0 raises `req` during c1's ACCESS cycle. Expect no `c0_gnt` until the following IDLE cycle, and `c1_ack` asserted in that same cycle.
- Assert `rst_n`=0 during an ACCESS write of 0xFFFF to address 3 (RAM preloaded with 0x0021). Expect `ram_write_en` low at once, no `ack`, and address 3 still 0x0021.
- Write then read address 63 (max). Expect correct data and no aliasing onto address 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - client request/ack and RAM port B bundle for ram_port_arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  c0_req;
    logic                  c1_req;
    logic                  c0_we;
    logic                  c1_we;
    logic [ADDR_WIDTH-1:0] c0_addr;
    logic [ADDR_WIDTH-1:0] c1_addr;
    logic [DATA_WIDTH-1:0] c0_wdata;
    logic [DATA_WIDTH-1:0] c1_wdata;
    logic                  c0_gnt;
    logic                  c1_gnt;
    logic                  c0_ack;
    logic                  c1_ack;
    logic [DATA_WIDTH-1:0] c0_rdata;
    logic [DATA_WIDTH-1:0] c1_rdata;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic [DATA_WIDTH-1:0] ram_in_data;
    logic                  ram_write_en;
    logic [DATA_WIDTH-1:0] ram_data_b;

    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        input  ram_data_b,
        output c0_gnt, c1_gnt, c0_ack, c1_ack, c0_rdata, c1_rdata, busy,
        output ram_addr_b, ram_in_data, ram_write_en
    );

    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        output ram_data_b,
        input  c0_gnt, c1_gnt, c0_ack, c1_ack, c0_rdata, c1_rdata, busy,
        input  ram_addr_b, ram_in_data, ram_write_en
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-client arbiter/sequencer for RAM port B
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_port_arbiter_if.slave      bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state_q;
    logic                  ptr_q;
    logic                  owner_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  ram_we_q;

    logic                  grant_d;
    logic                  winner_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // Contention goes to ptr; a lone requester wins regardless of ptr.
    always_comb begin
        grant_d  = (state_q == IDLE) && (bus.c0_req || bus.c1_req);
        winner_d = (bus.c0_req && bus.c1_req) ? ptr_q : bus.c1_req;
        we_d     = winner_d ? bus.c1_we    : bus.c0_we;
        addr_d   = winner_d ? bus.c1_addr  : bus.c0_addr;
        wdata_d  = winner_d ? bus.c1_wdata : bus.c0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            ram_we_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    ram_we_q <= 1'b0;
                    if (grant_d) begin
                        owner_q  <= winner_d;
                        we_q     <= we_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        ptr_q    <= ~winner_d;
                        ram_we_q <= we_d;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM read is combinational, so data_b is valid on this closing edge.
                    if (!we_q) begin
                        if (owner_q) rdata1_q <= bus.ram_data_b;
                        else         rdata0_q <= bus.ram_data_b;
                    end
                    ack0_q   <= ~owner_q;
                    ack1_q   <= owner_q;
                    ram_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // addr_q/wdata_q only load on a grant, so the port holds its last values while idle.
    assign bus.c0_gnt       = grant_d && !winner_d;
    assign bus.c1_gnt       = grant_d && winner_d;
    assign bus.c0_ack       = ack0_q;
    assign bus.c1_ack       = ack1_q;
    assign bus.c0_rdata     = rdata0_q;
    assign bus.c1_rdata     = rdata1_q;
    assign bus.busy         = (state_q == ACCESS);
    assign bus.ram_addr_b   = addr_q;
    assign bus.ram_in_data  = wdata_q;
    assign bus.ram_write_en = ram_we_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench with transaction-level model for ram_port_arbiter
module tb_ram_port_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ram_port_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    ram_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM port B with combinational read
    logic [15:0] ram [64];
    always @(posedge clk) if (bus.ram_write_en) ram[bus.ram_addr_b] <= bus.ram_in_data;
    assign bus.ram_data_b = ram[bus.ram_addr_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycle numbers of the pending access and ack
    int          mcyc;
    int          m_acc;
    int          m_ackc;
    int          m_ackcl;
    int          m_prio;
    int          m_own;
    bit          m_we;
    logic [5:0]  m_addr;
    logic [15:0] m_wd;
    logic [15:0] m_rd [2];
    logic [15:0] m_mem [64];

    always @(negedge clk) begin
        bit busy_e;
        int w;
        bit g0;
        bit g1;
        mcyc++;
        if (!rst_n) begin
            chk("rst_write_en", 32'(bus.ram_write_en), 32'(0));
            chk("rst_busy", 32'(bus.busy), 32'(0));
            chk("rst_c0_ack", 32'(bus.c0_ack), 32'(0));
            chk("rst_c1_ack", 32'(bus.c1_ack), 32'(0));
            chk("rst_ram_addr", 32'(bus.ram_addr_b), 32'(0));
            chk("rst_ram_in", 32'(bus.ram_in_data), 32'(0));
            chk("rst_c0_rdata", 32'(bus.c0_rdata), 32'(0));
            chk("rst_c1_rdata", 32'(bus.c1_rdata), 32'(0));
            m_acc   = -1;
            m_ackc  = -1;
            m_ackcl = 0;
            m_prio  = 0;
            m_rd[0] = 16'h0;
            m_rd[1] = 16'h0;
        end else begin
            busy_e = (mcyc == m_acc);
            chk("m_busy", 32'(bus.busy), 32'(busy_e));
            chk("m_write_en", 32'(bus.ram_write_en), 32'(busy_e && m_we));
            if (busy_e) begin
                chk("m_ram_addr", 32'(bus.ram_addr_b), 32'(m_addr));
                if (m_we) chk("m_ram_in", 32'(bus.ram_in_data), 32'(m_wd));
            end
            chk("m_c0_ack", 32'(bus.c0_ack), 32'(mcyc == m_ackc && m_ackcl == 0));
            chk("m_c1_ack", 32'(bus.c1_ack), 32'(mcyc == m_ackc && m_ackcl == 1));
            chk("m_c0_rdata", 32'(bus.c0_rdata), 32'(m_rd[0]));
            chk("m_c1_rdata", 32'(bus.c1_rdata), 32'(m_rd[1]));
            g0 = 1'b0;
            g1 = 1'b0;
            if (!busy_e && (bus.c0_req || bus.c1_req)) begin
                w = (bus.c0_req && bus.c1_req) ? m_prio : (bus.c1_req ? 1 : 0);
                if (w == 1) begin
                    g1 = 1'b1; m_we = bus.c1_we; m_addr = bus.c1_addr; m_wd = bus.c1_wdata;
                end else begin
                    g0 = 1'b1; m_we = bus.c0_we; m_addr = bus.c0_addr; m_wd = bus.c0_wdata;
                end
                m_own   = w;
                m_acc   = mcyc + 1;
                m_ackc  = mcyc + 2;
                m_ackcl = w;
                m_prio  = 1 - w;
            end
            chk("m_c0_gnt", 32'(bus.c0_gnt), 32'(g0));
            chk("m_c1_gnt", 32'(bus.c1_gnt), 32'(g1));
            if (busy_e) begin
                if (m_we) m_mem[m_addr] = m_wd;
                else      m_rd[m_own] = m_mem[m_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int cl, input bit r, input bit we, input logic [5:0] a, input logic [15:0] d);
        if (cl == 1) begin
            bus.c1_req = r; bus.c1_we = we; bus.c1_addr = a; bus.c1_wdata = d;
        end else begin
            bus.c0_req = r; bus.c0_we = we; bus.c0_addr = a; bus.c0_wdata = d;
        end
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One access, req dropped in the ACCESS cycle; returns at mid ack cycle after checking ack.
    task automatic single(input int cl, input bit we, input logic [5:0] a, input logic [15:0] d);
        int n;
        step();
        set_req(cl, 1'b1, we, a, d);
        #3;
        n = 0;
        while (((cl == 1) ? bus.c1_gnt : bus.c0_gnt) !== 1'b1 && n < 20) begin
            step();
            #3;
            n++;
        end
        chk("gnt_wait_bound", 32'(n < 20), 32'(1));
        step();
        set_req(cl, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        #3;
        chk("single_ack", 32'((cl == 1) ? bus.c1_ack : bus.c0_ack), 32'(1));
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        ram[a]   = d;
        m_mem[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        mcyc   = 0;
        m_acc  = -1;
        m_ackc = -1;
        m_prio = 0;
        m_rd[0] = 16'h0;
        m_rd[1] = 16'h0;
        for (int i = 0; i < 64; i++) begin
            ram[i]   = 16'h0;
            m_mem[i] = 16'h0;
        end
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0);
        rst_n = 1'b1;
        #1;
        do_reset();

        // write 0x1234 to 5 with latency pins, then read it back
        step();
        set_req(0, 1'b1, 1'b1, 6'd5, 16'h1234);
        #3;
        chk("t1_gnt_n", 32'(bus.c0_gnt), 32'(1));
        chk("t1_we_n", 32'(bus.ram_write_en), 32'(0));
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        #3;
        chk("t1_we_n1", 32'(bus.ram_write_en), 32'(1));
        chk("t1_addr_n1", 32'(bus.ram_addr_b), 32'(5));
        chk("t1_ack_n1", 32'(bus.c0_ack), 32'(0));
        step();
        #3;
        chk("t1_ack_n2", 32'(bus.c0_ack), 32'(1));
        chk("t1_we_n2", 32'(bus.ram_write_en), 32'(0));
        single(0, 1'b0, 6'd5, 16'h0);
        chk("t1_rdata", 32'(bus.c0_rdata), 32'h1234);

        // both clients hold req: grants alternate every 2 cycles
        do_reset();
        step();
        set_req(0, 1'b1, 1'b1, 6'd1, 16'hAAAA);
        set_req(1, 1'b1, 1'b1, 6'd2, 16'h5555);
        for (int k = 0; k < 8; k++) begin
            #3;
            chk("t2_c0_gnt", 32'(bus.c0_gnt), 32'(k % 4 == 0));
            chk("t2_c1_gnt", 32'(bus.c1_gnt), 32'(k % 4 == 2));
            step();
        end
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        step();
        chk("t2_ram1", 32'(ram[1]), 32'hAAAA);
        chk("t2_ram2", 32'(ram[2]), 32'h5555);

        // lone c1 wins with ptr=0, then contention goes to c0
        do_reset();
        step();
        set_req(1, 1'b1, 1'b0, 6'd0, 16'h0);
        #3;
        chk("t3_c1_gnt", 32'(bus.c1_gnt), 32'(1));
        chk("t3_c0_gnt", 32'(bus.c0_gnt), 32'(0));
        step();
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        #3;
        chk("t3_c1_ack", 32'(bus.c1_ack), 32'(1));
        chk("t3_c1_rdata", 32'(bus.c1_rdata), 32'(0));
        step();
        set_req(0, 1'b1, 1'b0, 6'd1, 16'h0);
        set_req(1, 1'b1, 1'b0, 6'd2, 16'h0);
        #3;
        chk("t3_both_c0_gnt", 32'(bus.c0_gnt), 32'(1));
        chk("t3_both_c1_gnt", 32'(bus.c1_gnt), 32'(0));
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        #3;
        chk("t3_c0_rdata", 32'(bus.c0_rdata), 32'hAAAA);

        // c0 raises req during c1's ACCESS: granted only next IDLE, alongside c1_ack
        step();
        set_req(1, 1'b1, 1'b0, 6'd2, 16'h0);
        #3;
        chk("t4_c1_gnt", 32'(bus.c1_gnt), 32'(1));
        step();
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0);
        set_req(0, 1'b1, 1'b0, 6'd5, 16'h0);
        #3;
        chk("t4_c0_no_gnt", 32'(bus.c0_gnt), 32'(0));
        chk("t4_busy", 32'(bus.busy), 32'(1));
        step();
        #3;
        chk("t4_c0_gnt", 32'(bus.c0_gnt), 32'(1));
        chk("t4_c1_ack", 32'(bus.c1_ack), 32'(1));
        chk("t4_c1_rdata", 32'(bus.c1_rdata), 32'h5555);
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        #3;
        chk("t4_c0_ack", 32'(bus.c0_ack), 32'(1));
        chk("t4_c0_rdata", 32'(bus.c0_rdata), 32'h1234);

        // reset in the middle of a write ACCESS
        preload(6'd3, 16'h0021);
        step();
        set_req(0, 1'b1, 1'b1, 6'd3, 16'hFFFF);
        #3;
        chk("t5_gnt", 32'(bus.c0_gnt), 32'(1));
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0);
        #1;
        chk("t5_we_before", 32'(bus.ram_write_en), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_we_drop", 32'(bus.ram_write_en), 32'(0));
        chk("t5_busy_drop", 32'(bus.busy), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("t5_no_ack", 32'(bus.c0_ack), 32'(0));
            step();
        end
        chk("t5_ram3", 32'(ram[3]), 32'h0021);

        // max address, no aliasing onto 0
        single(0, 1'b1, 6'd63, 16'hBEEF);
        single(0, 1'b0, 6'd63, 16'h0);
        chk("t6_rdata", 32'(bus.c0_rdata), 32'hBEEF);
        chk("t6_ram63", 32'(ram[63]), 32'hBEEF);
        chk("t6_ram0", 32'(ram[0]), 32'h0);

        step();
        for (int i = 0; i < 64; i++) chk("final_mem", 32'(ram[i]), 32'(m_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
